// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the IF and DM pipeline stages.
// DM has fixed priority; IF is forced in after STARVE_MAX consecutive DM wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              if_err,
  output logic              dm_err
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              if_gnt_d, dm_gnt_d, if_valid_d, dm_valid_d;
  logic              err_d, if_err_d, dm_err_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    err_d       = 1'b0;
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    unique case (state_q)
      IDLE: begin
        // A DM win can only happen below STARVE_TOP, so the increment never overflows.
        if (dm_req && (!if_req || starve_q < STARVE_TOP)) begin
          state_d     = BUSY_DM;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          dm_gnt_d    = 1'b1;
          tmo_d       = '0;
          if (if_req) starve_d = starve_q + SW'(1);
        end else if (if_req) begin
          state_d    = BUSY_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          if_gnt_d   = 1'b1;
          tmo_d      = '0;
          starve_d   = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_we) dm_rdata_d = mem_rdata;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          err_d    = 1'b1;
          if_err_d = (state_q == BUSY_IF);
          dm_err_d = (state_q == BUSY_DM);
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      tmo_q     <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
      if_err    <= 1'b0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      err       <= err_d;
      if_err    <= if_err_d;
      dm_err    <= dm_err_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model compared every
// cycle, directed literal scenarios, then randomized requesters and memory.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
  localparam int TMO  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_valid, if_stall, dm_gnt, dm_valid, dm_stall;
  logic        mem_en, mem_we, err, if_err, dm_err;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(SMAX), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err), .if_err(if_err), .dm_err(dm_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner 0=none, 1=IF, 2=DM; age = busy cycles already spent.
  int          m_owner, m_age, m_starve;
  logic        m_en, m_we;
  logic [15:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic        m_if_gnt, m_dm_gnt, m_if_valid, m_dm_valid, m_err, m_if_err, m_dm_err;

  function automatic void model_reset();
    m_owner = 0; m_age = 0; m_starve = 0;
    m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
    m_if_gnt = 0; m_dm_gnt = 0; m_if_valid = 0; m_dm_valid = 0;
    m_err = 0; m_if_err = 0; m_dm_err = 0;
  endfunction

  function automatic void model_step();
    m_if_gnt = 0; m_dm_gnt = 0; m_if_valid = 0; m_dm_valid = 0;
    m_err = 0; m_if_err = 0; m_dm_err = 0;
    if (m_owner == 0) begin
      if (dm_req && (!if_req || m_starve < SMAX)) begin
        m_owner = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_dm_gnt = 1;
        if (if_req) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
      end else if (if_req) begin
        m_owner = 1; m_we = 0; m_addr = if_addr; m_if_gnt = 1; m_starve = 0;
      end
      m_age = 0;
      m_en  = (m_owner != 0);
    end else begin
      m_age++;
      if (mem_ready) begin
        if (m_owner == 1) begin m_if_valid = 1; m_if_rdata = mem_rdata; end
        else begin m_dm_valid = 1; if (!m_we) m_dm_rdata = mem_rdata; end
        m_owner = 0; m_en = 0; m_we = 0;
      end else if (m_age >= TMO) begin
        m_err = 1; m_if_err = (m_owner == 1); m_dm_err = (m_owner == 2);
        m_owner = 0; m_en = 0; m_we = 0;
      end
    end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("if_gnt", if_gnt, m_if_gnt);
        chk("dm_gnt", dm_gnt, m_dm_gnt);
        chk("if_valid", if_valid, m_if_valid);
        chk("dm_valid", dm_valid, m_dm_valid);
        chk("err", err, m_err);
        chk("if_err", if_err, m_if_err);
        chk("dm_err", dm_err, m_dm_err);
        chk("mem_en", mem_en, m_en);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_rdata", if_rdata, m_if_rdata);
        chk("dm_rdata", dm_rdata, m_dm_rdata);
        chk("if_stall", if_stall, if_req & ~m_if_valid);
        chk("dm_stall", dm_stall, dm_req & ~m_dm_valid);
      end
    end
  end

  int grants[$];
  int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
  int c_dmgnt, c_err, c_dmerr, c_ifgnt, c_dmvalid, c_iferr;
  int stall_cnt;

  initial begin
    reset = 1'b1;
    if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #2 reset = 1'b0;
    @(posedge clk); #1 cmp_en = 1;
    @(negedge clk); #1 reset = 1'b1;

    // Reset while a DM read is in flight.
    dm_req = 1; dm_we = 0; dm_addr = 16'h0099; mem_ready = 0;
    @(negedge clk);
    chk("t1_gnt", dm_gnt, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t1_rst_en", mem_en, 0);
    chk("t1_rst_addr", mem_addr, 0);
    chk("t1_rst_gnt", dm_gnt, 0);
    chk("t1_rst_valid", dm_valid, 0);
    chk("t1_rst_err", err, 0);
    dm_req = 0; mem_ready = 1;
    @(negedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_idle_en", mem_en, 0);
      chk("t1_idle_valid", {if_valid, dm_valid, err}, 0);
    end
    #1 mem_ready = 0;

    // IF read of 0x0010 returning 0xBEEF.
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    chk("t2_gnt", if_gnt, 1);
    chk("t2_addr", mem_addr, 16'h0010);
    chk("t2_en", mem_en, 1);
    @(negedge clk);
    chk("t2_novalid", if_valid, 0);
    chk("t2_stall", if_stall, 1);
    #1 mem_ready = 1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    chk("t2_valid", if_valid, 1);
    chk("t2_rdata", if_rdata, 16'hBEEF);
    chk("t2_stall_lo", if_stall, 0);
    #1 if_req = 0; mem_ready = 0; mem_rdata = '0;
    @(negedge clk);
    chk("t2_rdata_held", if_rdata, 16'hBEEF);

    // DM read, then a DM write that must leave dm_rdata alone.
    #1 dm_req = 1; dm_we = 0; dm_addr = 16'h0050; mem_ready = 1; mem_rdata = 16'h5A5A;
    @(negedge clk);
    chk("t3_rd_gnt", dm_gnt, 1);
    @(negedge clk);
    chk("t3_rd_valid", dm_valid, 1);
    chk("t3_rd_data", dm_rdata, 16'h5A5A);
    #1 dm_we = 1; dm_addr = 16'h0020; dm_wdata = 16'h1234; mem_ready = 0; mem_rdata = 16'hFFFF;
    @(negedge clk);
    chk("t3_wr_gnt", dm_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_wr_held", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0020, 16'h1234});
      chk("t3_wr_novalid", dm_valid, 0);
    end
    #1 mem_ready = 1;
    @(negedge clk);
    chk("t3_wr_valid", dm_valid, 1);
    chk("t3_wr_rdata", dm_rdata, 16'h5A5A);
    chk("t3_wr_en", mem_en, 0);
    #1 dm_req = 0; dm_we = 0;

    // Both requesters held with an always-ready memory: starvation guard order.
    @(negedge clk); #1;
    if_req = 1; if_addr = 16'h0100; dm_req = 1; dm_addr = 16'h0200; mem_ready = 1;
    grants.delete();
    for (int i = 0; i < 60 && grants.size() < 10; i++) begin
      @(negedge clk);
      if (dm_gnt) grants.push_back(2);
      if (if_gnt) grants.push_back(1);
    end
    #1 if_req = 0; dm_req = 0;
    chk("t4_count", grants.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4_order[%0d]", i), (i < grants.size()) ? grants[i] : -1, exp_order[i]);
    repeat (2) @(negedge clk);

    // Simultaneous requests, DM read times out, pending IF follows.
    #1 dm_req = 1; dm_we = 0; dm_addr = 16'h0030; if_req = 1; if_addr = 16'h0040; mem_ready = 0;
    c_dmgnt = -1; c_err = -1; c_dmerr = -1; c_ifgnt = -1; c_dmvalid = -1; c_iferr = -1;
    for (int c = 1; c <= 40 && c_ifgnt < 0; c++) begin
      @(negedge clk);
      if (dm_gnt && c_dmgnt < 0) c_dmgnt = c;
      if (err && c_err < 0) c_err = c;
      if (dm_err && c_dmerr < 0) c_dmerr = c;
      if (if_err && c_iferr < 0) c_iferr = c;
      if (dm_valid && c_dmvalid < 0) c_dmvalid = c;
      if (if_gnt && c_ifgnt < 0) c_ifgnt = c;
      if (err) begin #1 dm_req = 0; end
    end
    chk("t5_dm_gnt_cycle", c_dmgnt, 1);
    chk("t5_err_cycle", c_err, 16);
    chk("t5_dm_err_cycle", c_dmerr, 16);
    chk("t5_no_if_err", c_iferr, -1);
    chk("t5_no_dm_valid", c_dmvalid, -1);
    chk("t6_if_gnt_cycle", c_ifgnt, 17);
    #1 mem_ready = 1; mem_rdata = 16'hC0DE;
    @(negedge clk);
    chk("t6_if_valid", if_valid, 1);
    chk("t6_if_rdata", if_rdata, 16'hC0DE);
    #1 if_req = 0; mem_ready = 0;
    @(negedge clk);

    // Randomized traffic with drops, idle-time ready, stalls and one async reset.
    stall_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      if (cyc == 1500) begin
        reset = 0; if_req = 0; dm_req = 0; mem_ready = 0; stall_cnt = 0;
        repeat (2) @(negedge clk);
        #1 reset = 1;
        continue;
      end
      if (if_req) begin
        if (if_valid || if_err || $urandom_range(0, 99) < 2) if_req = 0;
      end else if ($urandom_range(0, 99) < 40) begin
        if_req = 1; if_addr = 16'($urandom);
      end
      if (dm_req) begin
        if (dm_valid || dm_err || $urandom_range(0, 99) < 2) dm_req = 0;
      end else if ($urandom_range(0, 99) < 45) begin
        dm_req = 1; dm_we = 1'($urandom_range(0, 1));
        dm_addr = 16'($urandom); dm_wdata = 16'($urandom);
      end
      mem_rdata = 16'($urandom);
      if (stall_cnt > 0) begin
        mem_ready = 0; stall_cnt--;
      end else if ($urandom_range(0, 99) < 3) begin
        mem_ready = 0; stall_cnt = 20;
      end else begin
        mem_ready = ($urandom_range(0, 99) < 55);
      end
    end
    if_req = 0; dm_req = 0; mem_ready = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
